mcp3008_responder: RTL and testbench

Slave-side model of the MCP3008 10-bit SPI ADC, clocked from the FPGA system clock. It oversamples the SPI pins, decodes the 5-bit start/config command and latches the selected channel code from a parallel input bus. It then shifts the conversion result out exactly as the device does: null bit, MSB-first word, LSB-first repeat. It is used as an in-fabric stand-in for the ADC, so the acquisition path can be exercised without the part fitted.

---
 rtl/mcp3008_responder_if.sv | 18 +
 rtl/mcp3008_responder.sv | 197 +++++++++++++++++++
 tb/tb_mcp3008_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mcp3008_responder_if.sv
// SPI pin bundle between an acquisition master and the MCP3008 stand-in.
interface mcp3008_responder_if;
    logic spi_clk;
    logic spi_cs_n;
    logic spi_din;
    logic spi_dout;
    logic spi_dout_oe;

    modport master (
        output spi_clk, spi_cs_n, spi_din,
        input  spi_dout, spi_dout_oe
    );

    modport slave (
        input  spi_clk, spi_cs_n, spi_din,
        output spi_dout, spi_dout_oe
    );
endinterface

// File: rtl/mcp3008_responder.sv
// In-fabric MCP3008 slave model: oversampled SPI, command decode, channel-code
// latch and serial result (null bit, MSB-first word, optional LSB-first repeat).
module mcp3008_responder #(
    parameter int SYNC_STAGES = 2,
    parameter bit LSB_TRAIL   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    mcp3008_responder_if.slave        spi,
    input  logic [79:0]               ch_data,
    output logic                      conv_strobe,
    output logic                      conv_sgl,
    output logic [2:0]                conv_chan,
    output logic [9:0]                conv_code,
    output logic                      busy
);

    typedef enum logic [2:0] {
        IDLE, WAIT_START, CMD, SAMPLE, NULLB, MSB, LSB, TRAIL
    } state_t;

    // Synchronizer lanes: bit 0 = spi_clk, bit 1 = spi_cs_n, bit 2 = spi_din.
    logic [2:0]                   pins;
    logic [SYNC_STAGES-1:0][2:0]  sync_reg;
    logic                         clk_prev_reg;
    logic                         clk_s, cs_s, din_s, rise, fall;

    assign pins = {spi.spi_din, spi.spi_cs_n, spi.spi_clk};

    // cs_n lanes come out of reset deasserted so no transaction is seen early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= 3'b010;
            end
            clk_prev_reg <= 1'b0;
        end else begin
            sync_reg[0] <= pins;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= sync_reg[s-1];
            end
            clk_prev_reg <= sync_reg[SYNC_STAGES-1][0];
        end
    end

    assign clk_s = sync_reg[SYNC_STAGES-1][0];
    assign cs_s  = sync_reg[SYNC_STAGES-1][1];
    assign din_s = sync_reg[SYNC_STAGES-1][2];
    assign rise  = clk_s & ~clk_prev_reg;
    assign fall  = ~clk_s & clk_prev_reg;

    logic [9:0] ch [8];
    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
        assign ch[gi] = ch_data[10*gi +: 10];
    end

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [3:0] cmd_reg, cmd_next;
    logic       dout_reg, dout_next;
    logic       oe_reg, oe_next;
    logic       busy_reg, busy_next;
    logic       strobe_reg, strobe_next;
    logic       sgl_reg, sgl_next;
    logic [2:0] chan_reg, chan_next;
    logic [9:0] code_reg, code_next;

    // Differential: IN+ is always CH[chan], IN- its pair partner; negative clamps to 0.
    logic [10:0] diff;
    logic [9:0]  code_calc;
    assign diff      = {1'b0, ch[cmd_reg[2:0]]}
                     - (cmd_reg[3] ? 11'd0 : {1'b0, ch[cmd_reg[2:0] ^ 3'd1]});
    assign code_calc = diff[10] ? 10'd0 : diff[9:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            cmd_reg    <= 4'd0;
            dout_reg   <= 1'b0;
            oe_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            strobe_reg <= 1'b0;
            sgl_reg    <= 1'b0;
            chan_reg   <= 3'd0;
            code_reg   <= 10'd0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            cmd_reg    <= cmd_next;
            dout_reg   <= dout_next;
            oe_reg     <= oe_next;
            busy_reg   <= busy_next;
            strobe_reg <= strobe_next;
            sgl_reg    <= sgl_next;
            chan_reg   <= chan_next;
            code_reg   <= code_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        cmd_next    = cmd_reg;
        dout_next   = dout_reg;
        oe_next     = oe_reg;
        busy_next   = busy_reg;
        strobe_next = 1'b0;
        sgl_next    = sgl_reg;
        chan_next   = chan_reg;
        code_next   = code_reg;

        // A deasserted chip select overrides any coincident spi_clk event.
        if (cs_s) begin
            state_next = IDLE;
            cnt_next   = 4'd0;
            dout_next  = 1'b0;
            oe_next    = 1'b0;
            busy_next  = 1'b0;
        end else begin
            case (state_reg)
                IDLE: state_next = WAIT_START;
                WAIT_START: begin
                    if (rise && din_s) begin
                        state_next = CMD;
                        busy_next  = 1'b1;
                        cnt_next   = 4'd0;
                    end
                end
                CMD: begin
                    if (rise) begin
                        cmd_next = {cmd_reg[2:0], din_s};
                        if (cnt_reg == 4'd3) begin
                            state_next = SAMPLE;
                            cnt_next   = 4'd0;
                        end else begin
                            cnt_next = cnt_reg + 4'd1;
                        end
                    end
                end
                SAMPLE: begin
                    if (fall) begin
                        sgl_next    = cmd_reg[3];
                        chan_next   = cmd_reg[2:0];
                        code_next   = code_calc;
                        strobe_next = 1'b1;
                        state_next  = NULLB;
                    end
                end
                NULLB: begin
                    if (fall) begin
                        oe_next    = 1'b1;
                        dout_next  = 1'b0;
                        cnt_next   = 4'd0;
                        state_next = MSB;
                    end
                end
                MSB: begin
                    if (fall) begin
                        dout_next = code_reg[4'd9 - cnt_reg];
                        if (cnt_reg == 4'd9) begin
                            cnt_next   = 4'd0;
                            state_next = LSB_TRAIL ? LSB : TRAIL;
                        end else begin
                            cnt_next = cnt_reg + 4'd1;
                        end
                    end
                end
                LSB: begin
                    if (fall) begin
                        dout_next = code_reg[cnt_reg + 4'd1];
                        if (cnt_reg == 4'd8) begin
                            state_next = TRAIL;
                        end else begin
                            cnt_next = cnt_reg + 4'd1;
                        end
                    end
                end
                TRAIL: begin
                    if (fall) begin
                        dout_next = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign spi.spi_dout    = dout_reg;
    assign spi.spi_dout_oe = oe_reg;
    assign conv_strobe     = strobe_reg;
    assign conv_sgl        = sgl_reg;
    assign conv_chan       = chan_reg;
    assign conv_code       = code_reg;
    assign busy            = busy_reg;

endmodule

// File: tb/tb_mcp3008_responder.sv
// Scoreboard bench for mcp3008_responder: stimulus queues expected codes and
// serial bits, monitors pop them on conv_strobe and on master-side rising edges.
module tb_mcp3008_responder;
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        din = 1'b0;
    logic [79:0] ch_data = '0;

    mcp3008_responder_if spi_a ();
    mcp3008_responder_if spi_b ();

    assign spi_a.spi_clk  = sclk;
    assign spi_a.spi_cs_n = cs_n;
    assign spi_a.spi_din  = din;
    assign spi_b.spi_clk  = sclk;
    assign spi_b.spi_cs_n = cs_n;
    assign spi_b.spi_din  = din;

    logic       strobe_a, sgl_a, busy_a;
    logic [2:0] chan_a;
    logic [9:0] code_a;
    logic       strobe_b, sgl_b, busy_b;
    logic [2:0] chan_b;
    logic [9:0] code_b;

    mcp3008_responder #(.SYNC_STAGES(2), .LSB_TRAIL(1'b1)) u_dut (
        .clk(clk), .rst(rst), .spi(spi_a), .ch_data(ch_data),
        .conv_strobe(strobe_a), .conv_sgl(sgl_a), .conv_chan(chan_a),
        .conv_code(code_a), .busy(busy_a)
    );

    mcp3008_responder #(.SYNC_STAGES(2), .LSB_TRAIL(1'b0)) u_dut_nolsb (
        .clk(clk), .rst(rst), .spi(spi_b), .ch_data(ch_data),
        .conv_strobe(strobe_b), .conv_sgl(sgl_b), .conv_chan(chan_b),
        .conv_code(code_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [13:0] code_q [$];
    logic        bq_a [$];
    logic        bq_b [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Conversion scoreboard: one expected {sgl,chan,code} per strobe cycle.
    always @(negedge clk) begin
        if (strobe_a === 1'b1) begin
            checks++;
            if (code_q.size() == 0) begin
                failures++;
                $display("FAIL strobe: unexpected strobe with code %h", code_a);
            end else begin
                logic [13:0] e;
                e = code_q.pop_front();
                if ({sgl_a, chan_a, code_a} !== e) begin
                    failures++;
                    $display("FAIL conv: got sgl/chan/code %h expected %h", {sgl_a, chan_a, code_a}, e);
                end
            end
        end
    end

    // Serial scoreboard: every master rising edge with oe set consumes one bit.
    always @(posedge sclk) begin
        if (spi_a.spi_dout_oe === 1'b1) begin
            checks++;
            if (bq_a.size() == 0) begin
                failures++;
                $display("FAIL dout_lsb: unexpected driven bit %b", spi_a.spi_dout);
            end else begin
                logic e;
                e = bq_a.pop_front();
                if (spi_a.spi_dout !== e) begin
                    failures++;
                    $display("FAIL dout_lsb: got %b expected %b", spi_a.spi_dout, e);
                end
            end
        end
        if (spi_b.spi_dout_oe === 1'b1) begin
            checks++;
            if (bq_b.size() == 0) begin
                failures++;
                $display("FAIL dout_nolsb: unexpected driven bit %b", spi_b.spi_dout);
            end else begin
                logic e;
                e = bq_b.pop_front();
                if (spi_b.spi_dout !== e) begin
                    failures++;
                    $display("FAIL dout_nolsb: got %b expected %b", spi_b.spi_dout, e);
                end
            end
        end
    end

    // Bit seen at the j-th rise after the null-bit rise (j=0 is the null bit).
    function automatic logic exp_bit(input logic [9:0] code, input int j, input logic lsb);
        if (j == 0)               return 1'b0;
        else if (j <= 10)         return code[10-j];
        else if (j <= 19 && lsb)  return code[j-10];
        else                      return 1'b0;
    endfunction

    task automatic set_ch(input int k, input logic [9:0] v);
        ch_data[10*k +: 10] = v;
    endtask

    task automatic spi_bit(input logic b);
        din = b;
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic xfer(input logic sgl, input logic [2:0] chan, input int lead,
                        input int nrise, input logic [9:0] code, input int poke);
        logic [4:0] cmd;
        cmd = {1'b1, sgl, chan};
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < lead; i++) spi_bit(1'b0);
        if (lead > 0) check("lead_zero_idle", {busy_a, spi_a.spi_dout_oe}, 32'd0);
        code_q.push_back({sgl, chan, code});
        for (int k = 0; k < nrise; k++) begin
            if (k >= 6) begin
                bq_a.push_back(exp_bit(code, k-6, 1'b1));
                bq_b.push_back(exp_bit(code, k-6, 1'b0));
            end
            if (k == poke) ch_data = ~ch_data;
            spi_bit(k < 5 ? cmd[4-k] : 1'b0);
        end
    endtask

    task automatic drained(input string name);
        check({name, "_drained"}, code_q.size() + bq_a.size() + bq_b.size(), 32'd0);
        code_q.delete();
        bq_a.delete();
        bq_b.delete();
    endtask

    task automatic end_xfer(input string name);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        drained(name);
        $display("xfer %s: conv sgl=%0d chan=%0d code=%h", name, sgl_a, chan_a, code_a);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state", {spi_a.spi_dout, spi_a.spi_dout_oe, strobe_a, sgl_a, chan_a, code_a, busy_a,
                              spi_b.spi_dout, spi_b.spi_dout_oe, busy_b}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        set_ch(0, 10'h2A5);
        xfer(1'b1, 3'd0, 0, 26, 10'h2A5, -1);
        end_xfer("single_ch0");

        set_ch(0, 10'd300);
        set_ch(1, 10'd100);
        xfer(1'b0, 3'd0, 0, 17, 10'd200, -1);
        end_xfer("diff_0_1");
        xfer(1'b0, 3'd1, 0, 17, 10'd0, -1);
        end_xfer("diff_1_0_clamp");
        set_ch(2, 10'h3FF);
        set_ch(3, 10'h000);
        xfer(1'b0, 3'd2, 0, 17, 10'h3FF, -1);
        end_xfer("diff_2_3_full");

        set_ch(7, 10'h001);
        xfer(1'b1, 3'd7, 3, 17, 10'h001, -1);
        end_xfer("lead_zeros_ch7");

        set_ch(4, 10'h155);
        xfer(1'b1, 3'd4, 0, 9, 10'h155, -1);
        check("abort_active", {busy_a, spi_a.spi_dout_oe}, 32'd3);
        cs_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_idle", {busy_a, spi_a.spi_dout_oe, spi_a.spi_dout,
                             busy_b, spi_b.spi_dout_oe, spi_b.spi_dout}, 32'd0);
        repeat (10) @(negedge clk);
        drained("abort");
        set_ch(3, 10'h1C7);
        xfer(1'b1, 3'd3, 0, 26, 10'h1C7, -1);
        end_xfer("after_abort_ch3");

        set_ch(5, 10'h3C6);
        xfer(1'b1, 3'd5, 0, 40, 10'h3C6, 8);
        end_xfer("trail_ch5");

        set_ch(6, 10'h2D9);
        xfer(1'b1, 3'd6, 0, 11, 10'h2D9, -1);
        rst = 1'b1;
        #1;
        check("reset_mid", {spi_a.spi_dout, spi_a.spi_dout_oe, strobe_a, sgl_a, chan_a, code_a, busy_a,
                            spi_b.spi_dout, spi_b.spi_dout_oe, busy_b}, 32'd0);
        repeat (3) @(negedge clk);
        drained("reset_mid");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        set_ch(2, 10'h0F0);
        xfer(1'b1, 3'd2, 3, 17, 10'h0F0, -1);
        end_xfer("after_reset_ch2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
